// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - word-to-bit-stream serializer with running ones count
// Accepts a WIDTH-bit word on a valid/ready handshake and emits it one bit per accepted serial beat.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter int CNTW      = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             bit_valid,
  input  logic             bit_ready,
  output logic             bit_out,
  output logic             bit_last,
  output logic [CNTW-1:0]  ones_cnt,
  output logic             done
);

  localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] sreg;
  logic [IDXW-1:0]  idx;

  // Head of the shift register is the bit currently on the wire; emptied positions fill with 0.
  assign bit_out = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sreg      <= '0;
      idx       <= '0;
      ones_cnt  <= '0;
      in_ready  <= 1'b1;
      bit_valid <= 1'b0;
      bit_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (in_valid) begin
            sreg      <= in_data;
            idx       <= '0;
            ones_cnt  <= '0;
            in_ready  <= 1'b0;
            bit_valid <= 1'b1;
            bit_last  <= 1'b0;
            state     <= SHIFT;
          end
        end

        SHIFT: begin
          if (bit_ready) begin
            ones_cnt <= ones_cnt + {{(CNTW-1){1'b0}}, bit_out};
            if (MSB_FIRST) begin
              sreg <= {sreg[WIDTH-2:0], 1'b0};
            end else begin
              sreg <= {1'b0, sreg[WIDTH-1:1]};
            end
            // Index parks at 0 after the final bit rather than wrapping past WIDTH-1.
            if (bit_last) begin
              idx       <= '0;
              bit_valid <= 1'b0;
              bit_last  <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              idx      <= idx + IDXW'(1);
              bit_last <= ((idx + IDXW'(1)) == LAST_IDX);
            end
          end
        end

        DONE: begin
          done     <= 1'b0;
          in_ready <= 1'b1;
          state    <= IDLE;
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          bit_valid <= 1'b0;
          bit_last  <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
Transmit-side partner of the parallel bit classifier: accepts an 8-bit word over a valid/ready handshake and emits it one bit per accepted beat on a serial valid/ready stream. Keeps a running count of the 1-bits sent and pulses done after the final bit, so a downstream serial receiver can check results against the source word. It sits between a parallel producer and a bit-serial consumer.

Parameters:
WIDTH, 8, word width in bits (≥2).
CNTW, 4, width of ones_cnt; must satisfy 2^CNTW > WIDTH.
MSB_FIRST, 1, 1 = bit WIDTH-1 sent first, 0 = bit 0 sent first.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-high reset.
in_valid  input  1  in_data is valid.
in_data  input  WIDTH  word to serialize.
in_ready  output  1  block can accept a word (high only in IDLE).
bit_valid  output  1  bit_out is valid.
bit_ready  input  1  consumer accepts bit_out this cycle.
bit_out  output  1  current serial bit.
bit_last  output  1  bit_out is the final bit of the word.
ones_cnt  output  CNTW  number of 1-bits accepted so far in the current word.
done  output  1  one-cycle pulse after the final bit is accepted.

Behaviour:
- State machine: IDLE, SHIFT, DONE. reset forces IDLE immediately, without waiting for a clock edge.
- Reset values: in_ready=1 (IDLE), bit_valid=0, bit_out=0, bit_last=0, ones_cnt=0, done=0, shift register=0, bit index=0.
- All outputs decode from registers only, with no combinational path from any input to any output. bit_out = shift register head.
- IDLE: in_ready=1, bit_valid=0. On in_valid=1 at an edge:
  - load in_data into the shift register,
  - set index=0 and ones_cnt=0,
  - go to SHIFT.
  - With in_valid=0, hold all state.
- SHIFT: in_ready=1 is never asserted here; in_valid is ignored.
  - bit_valid=1.
  - bit_last=1 only when index=WIDTH-1.
  - An accept is bit_valid & bit_ready at an edge. On each accept:
    - ones_cnt += bit_out,
    - shift toward the head (left for MSB_FIRST=1, right otherwise), filling with 0,
    - index += 1.
  - On the accept with bit_last=1, go to DONE.
  - With bit_ready=0, hold bit_out, bit_last, ones_cnt and index unchanged. Stalls of any length are allowed.
- DONE: exactly one cycle.
  - done=1, bit_valid=0, in_ready=0.
  - ones_cnt holds the word total (0..WIDTH).
  - Next state is always IDLE.
- ones_cnt holds its value through DONE and IDLE. It clears only when the next word is loaded.
- Latency:
  - Word accepted at edge k → first bit valid in cycle k+1.
  - With bit_ready held high: last bit in cycle k+WIDTH, done in cycle k+WIDTH+1, in_ready again in cycle k+WIDTH+2.
  - Peak throughput is one word per WIDTH+2 cycles.
- Arithmetic: index counts 0..WIDTH-1 and never wraps inside a word. ones_cnt cannot overflow because of the CNTW constraint.
- Reset mid-word: the partial word is discarded and no done pulse is produced. The first cycle after reset deasserts shows IDLE values.
- If in_valid and reset are both high, reset wins.

Test Plan:
1. Reset while idle → in_ready=1, bit_valid=0, ones_cnt=0, done=0. Assert reset asynchronously between edges → outputs take reset values before the next edge.
2. MSB_FIRST=1, load 8'hA5, bit_ready=1 → bit_out sequence 1,0,1,0,0,1,0,1. bit_last high only on the 8th bit. done in the following cycle with ones_cnt=4. in_ready returns one cycle later.
3. MSB_FIRST=0, load 8'h01 → first bit 1, then seven 0s. ones_cnt=1 at done. Load 8'h00 → ones_cnt=0. Load 8'hFF → ones_cnt=8.
4. Load 8'hC3 and drop bit_ready for 3 cycles after bit 2 → bit_out, bit_last and ones_cnt are frozen during the stall. Sequence 1,1,0,0,0,0,1,1 completes with ones_cnt=4.
5. Hold in_valid=1 with changing in_data during SHIFT → in_ready=0 and the transmitted word is unchanged. The next word is accepted only in the IDLE cycle after done.
6. Assert reset after the 4th bit of 8'hF0 → state is IDLE, ones_cnt=0, and no done pulse occurs. A subsequent load of 8'h0F is sent correctly and gives ones_cnt=4.
